// File: rtl/ram_arbiter.sv
// Two-port arbiter and access sequencer for the shared Master_CPU RAM.
// Port A is instruction fetch and port B is load/store. One access runs at a time, and each completion is signalled with a one-cycle Ack.
module ram_arbiter #(
   parameter int unsigned ADDR_W        = 16,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned PRIORITY_A    = 0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              A_Req,
   input  logic              A_RW,
   input  logic [ADDR_W-1:0] A_Address,
   input  logic [DATA_W-1:0] A_WData,
   output logic              A_Ack,
   output logic [DATA_W-1:0] A_RData,
   input  logic              B_Req,
   input  logic              B_RW,
   input  logic [ADDR_W-1:0] B_Address,
   input  logic [DATA_W-1:0] B_WData,
   output logic              B_Ack,
   output logic [DATA_W-1:0] B_RData,
   output logic              Mem_Enable,
   output logic              Mem_RW,
   output logic [ADDR_W-1:0] Mem_Address,
   output logic [DATA_W-1:0] Mem_In,
   input  logic [DATA_W-1:0] Mem_Out,
   output logic              Busy,
   output logic              Grant_B
);

   localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;   // 1 = B was granted last
   logic             pick_b;

   // Arbitration: a lone requester wins; a tie goes to A or alternates, depending on PRIORITY_A
   always_comb begin
      pick_b = 1'b0;
      if (B_Req && !A_Req) begin
         pick_b = 1'b1;
      end else if (A_Req && B_Req && (PRIORITY_A == 0)) begin
         pick_b = ~last_grant;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         cnt         <= '0;
         last_grant  <= 1'b1;
         Grant_B     <= 1'b0;
         Busy        <= 1'b0;
         A_Ack       <= 1'b0;
         B_Ack       <= 1'b0;
         A_RData     <= '0;
         B_RData     <= '0;
         Mem_Enable  <= 1'b0;
         Mem_RW      <= 1'b0;
         Mem_Address <= '0;
         Mem_In      <= '0;
      end else begin
         A_Ack <= 1'b0;
         B_Ack <= 1'b0;
         case (state)
            IDLE: begin
               if (A_Req || B_Req) begin
                  state       <= ACCESS;
                  cnt         <= CNT_W'(ACCESS_CYCLES - 1);
                  last_grant  <= pick_b;
                  Grant_B     <= pick_b;
                  Busy        <= 1'b1;
                  Mem_Enable  <= 1'b1;
                  Mem_RW      <= pick_b ? B_RW      : A_RW;
                  Mem_Address <= pick_b ? B_Address : A_Address;
                  Mem_In      <= pick_b ? B_WData   : A_WData;
               end
            end
            ACCESS: begin
               // The last enabled cycle captures the read data and schedules the Ack
               if (cnt == '0) begin
                  state      <= RESP;
                  Mem_Enable <= 1'b0;
                  if (Grant_B) begin
                     B_Ack <= 1'b1;
                     if (Mem_RW) B_RData <= Mem_Out;
                  end else begin
                     A_Ack <= 1'b1;
                     if (Mem_RW) A_RData <= Mem_Out;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               Busy       <= 1'b0;
               Mem_Enable <= 1'b0;
            end
         endcase
      end
   end

endmodule
